// File: rtl/lfsr_random_gen.sv
// Fibonacci LFSR random sample source with a valid/ready output slot.
// Optional repeat filter (drops samples equal to the last one delivered): RNG_REPEAT_FILTER_EN.
module lfsr_random_gen #(
   parameter int WIDTH = 8,
   parameter int OUT_W = 2,
   parameter int SEED  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             rand_ready,
   output logic             rand_valid,
   output logic [OUT_W-1:0] rand_num,
   output logic [WIDTH-1:0] lfsr_state,
   output logic             period_wrap
);

   generate
      if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
         $error("lfsr_random_gen: WIDTH must be within 3..16");
      end
      if (OUT_W < 1 || OUT_W > WIDTH - 1) begin : g_bad_out_w
         $error("lfsr_random_gen: OUT_W must be within 1..WIDTH-1");
      end
   endgenerate

   // Tap positions as a bit mask (bit n-1 set for 1-based tap n), maximal-length polynomials.
   function automatic logic [15:0] tap_mask(input int w);
      case (w)
         3:       return 16'h0006;
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

   localparam logic [15:0]      TAP_MASK = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAP_MASK[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] SEED_RAW = SEED[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_V   = (SEED_RAW == '0) ? ONE : SEED_RAW;

   function automatic logic [WIDTH-1:0] fix_zero(input logic [WIDTH-1:0] v);
      return (v == '0) ? ONE : v;
   endfunction

   logic [WIDTH-1:0] lfsr_reg, lfsr_next;
   logic [WIDTH-1:0] ref_seed_reg, ref_seed_next;
   logic [OUT_W-1:0] rand_num_reg, rand_num_next;
   logic             rand_valid_reg, rand_valid_next;
   logic             period_wrap_reg, period_wrap_next;
   logic [WIDTH-1:0] tap_terms;
   logic [WIDTH-1:0] shift_val;
   logic             feedback;
   logic             slot_free;
   logic             advance;
   logic             repeat_hit;
   logic             deliver;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_taps
         assign tap_terms[gi] = TAPS[gi] & lfsr_reg[gi];
      end
   endgenerate

   assign feedback  = ^tap_terms;
   assign shift_val = {lfsr_reg[WIDTH-2:0], feedback};
   assign slot_free = !rand_valid_reg | (rand_valid_reg & rand_ready);
   assign advance   = en & slot_free & !seed_load;
   assign deliver   = advance & (lfsr_reg != '0) & !repeat_hit;

`ifdef RNG_REPEAT_FILTER_EN
   // Remembers whether a sample has been delivered since reset or the last seed load.
   logic have_prev_reg, have_prev_next;

   assign repeat_hit = have_prev_reg & (shift_val[OUT_W-1:0] == rand_num_reg);

   always_comb begin
      have_prev_next = have_prev_reg;
      if (seed_load)
         have_prev_next = 1'b0;
      else if (deliver)
         have_prev_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         have_prev_reg <= 1'b0;
      else
         have_prev_reg <= have_prev_next;
   end
`else
   assign repeat_hit = 1'b0;
`endif

   always_comb begin
      lfsr_next        = lfsr_reg;
      ref_seed_next    = ref_seed_reg;
      rand_num_next    = rand_num_reg;
      rand_valid_next  = rand_valid_reg;
      period_wrap_next = 1'b0;
      if (seed_load) begin
         lfsr_next       = fix_zero(seed_in);
         ref_seed_next   = fix_zero(seed_in);
         rand_valid_next = 1'b0;
      end else if (lfsr_reg == '0) begin
         // Lock-up state can only come from an upset; recover without producing a sample.
         lfsr_next = ONE;
         if (rand_valid_reg & rand_ready)
            rand_valid_next = 1'b0;
      end else if (advance) begin
         lfsr_next        = shift_val;
         period_wrap_next = (shift_val == ref_seed_reg);
         if (repeat_hit) begin
            rand_valid_next = 1'b0;
         end else begin
            rand_num_next   = shift_val[OUT_W-1:0];
            rand_valid_next = 1'b1;
         end
      end else if (rand_valid_reg & rand_ready & !en) begin
         rand_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_reg        <= SEED_V;
         ref_seed_reg    <= SEED_V;
         rand_num_reg    <= '0;
         rand_valid_reg  <= 1'b0;
         period_wrap_reg <= 1'b0;
      end else begin
         lfsr_reg        <= lfsr_next;
         ref_seed_reg    <= ref_seed_next;
         rand_num_reg    <= rand_num_next;
         rand_valid_reg  <= rand_valid_next;
         period_wrap_reg <= period_wrap_next;
      end
   end

   assign rand_valid  = rand_valid_reg;
   assign rand_num    = rand_num_reg;
   assign lfsr_state  = lfsr_reg;
   assign period_wrap = period_wrap_reg;

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Directed bench for lfsr_random_gen at WIDTH=4, OUT_W=2, SEED=1 (x^4+x^3+1 sequence).
// Repeat-filter expectations follow RNG_REPEAT_FILTER_EN when it is defined for the build.
module tb_lfsr_random_gen;

   logic       clk = 1'b0;
   logic       rst, en, seed_load, rand_ready;
   logic [3:0] seed_in;
   logic       rand_valid, period_wrap;
   logic [1:0] rand_num;
   logic [3:0] lfsr_state;

   int checks = 0;
   int errors = 0;

   lfsr_random_gen #(.WIDTH(4), .OUT_W(2), .SEED(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .rand_ready (rand_ready),
      .rand_valid (rand_valid),
      .rand_num   (rand_num),
      .lfsr_state (lfsr_state),
      .period_wrap(period_wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic       ld;
      logic [3:0] seed;
      logic       rdy;
      logic       v;
      logic [1:0] num;
      logic [3:0] st;
      logic       wrap;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic l, input logic [3:0] s,
                       input logic rd);
      rst = r; en = e; seed_load = l; seed_in = s; rand_ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [1:0] num,
                            input logic [3:0] st, input logic wrap);
      $display("%s: valid=%0b num=%b state=%b wrap=%0b", tag, rand_valid, rand_num,
               lfsr_state, period_wrap);
      check({tag, " valid"}, {15'd0, rand_valid}, {15'd0, v});
      check({tag, " num"}, {14'd0, rand_num}, {14'd0, num});
      check({tag, " state"}, {12'd0, lfsr_state}, {12'd0, st});
      check({tag, " wrap"}, {15'd0, period_wrap}, {15'd0, wrap});
   endtask

   logic [3:0] seen [15];
   int dups, zeros;

   initial begin
      //            rst en ld seed   rdy  v  num    state    wrap
      vecs[0]  = '{1, 0, 0, 4'h0, 0, 0, 2'b00, 4'b0001, 0};
      vecs[1]  = '{0, 1, 0, 4'h0, 1, 1, 2'b10, 4'b0010, 0};
      vecs[2]  = '{0, 1, 0, 4'h0, 1, 1, 2'b00, 4'b0100, 0};
      vecs[3]  = '{0, 1, 0, 4'h0, 1, 1, 2'b01, 4'b1001, 0};
      vecs[4]  = '{0, 1, 0, 4'h0, 1, 1, 2'b11, 4'b0011, 0};
      vecs[5]  = '{0, 1, 0, 4'h0, 1, 1, 2'b10, 4'b0110, 0};
      vecs[6]  = '{0, 1, 0, 4'h0, 0, 1, 2'b10, 4'b0110, 0};
      vecs[7]  = '{0, 1, 0, 4'h0, 0, 1, 2'b10, 4'b0110, 0};
      vecs[8]  = '{0, 1, 0, 4'h0, 0, 1, 2'b10, 4'b0110, 0};
      vecs[9]  = '{0, 1, 0, 4'h0, 0, 1, 2'b10, 4'b0110, 0};
      vecs[10] = '{0, 1, 0, 4'h0, 0, 1, 2'b10, 4'b0110, 0};
      vecs[11] = '{0, 1, 0, 4'h0, 1, 1, 2'b01, 4'b1101, 0};
      vecs[12] = '{0, 0, 0, 4'h0, 1, 0, 2'b01, 4'b1101, 0};
      vecs[13] = '{0, 0, 0, 4'h0, 0, 0, 2'b01, 4'b1101, 0};
      vecs[14] = '{0, 1, 1, 4'h0, 1, 0, 2'b01, 4'b0001, 0};
      vecs[15] = '{0, 1, 1, 4'hC, 1, 0, 2'b01, 4'b1100, 0};
      vecs[16] = '{0, 1, 0, 4'h0, 1, 1, 2'b00, 4'b1000, 0};
      vecs[17] = '{0, 1, 0, 4'h0, 1, 1, 2'b01, 4'b0001, 0};
      vecs[18] = '{1, 1, 0, 4'h0, 1, 0, 2'b00, 4'b0001, 0};

      rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 4'h0; rand_ready = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].seed, vecs[i].rdy);
         check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].num, vecs[i].st, vecs[i].wrap);
      end

      // Full period from the reset seed: wrap pulses only when 0001 comes back.
      step(1, 0, 0, 4'h0, 0);
      for (int i = 0; i < 15; i++) begin
         step(0, 1, 0, 4'h0, 1);
         seen[i] = lfsr_state;
         $display("period%0d: state=%b wrap=%0b", i, lfsr_state, period_wrap);
         check($sformatf("period%0d wrap", i), {15'd0, period_wrap}, {15'd0, (i == 14)});
      end
      check("period end state", {12'd0, lfsr_state}, 16'h0001);
      dups = 0; zeros = 0;
      for (int i = 0; i < 15; i++) begin
         if (seen[i] == 4'h0) zeros++;
         for (int j = i + 1; j < 15; j++)
            if (seen[i] == seen[j]) dups++;
      end
      check("period duplicate states", dups[15:0], 16'd0);
      check("period zero states", zeros[15:0], 16'd0);
      step(0, 1, 0, 4'h0, 1);
      check_out("after wrap", 1'b1, 2'b10, 4'b0010, 1'b0);

      // Repeated low bits: 1110 -> 1100 (00) -> 1000 (00) -> 0001 (01).
      step(0, 0, 1, 4'hE, 1);
      check_out("rep load", 1'b0, 2'b10, 4'b1110, 1'b0);
      step(0, 1, 0, 4'h0, 1);
      check_out("rep first", 1'b1, 2'b00, 4'b1100, 1'b0);
      step(0, 1, 0, 4'h0, 1);
`ifdef RNG_REPEAT_FILTER_EN
      check_out("rep second", 1'b0, 2'b00, 4'b1000, 1'b0);
`else
      check_out("rep second", 1'b1, 2'b00, 4'b1000, 1'b0);
`endif
      step(0, 1, 0, 4'h0, 1);
      check_out("rep third", 1'b1, 2'b01, 4'b0001, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
